mem_stage: RTL
==============

# mem_stage

Memory-access stage of the five-stage LoongArch pipeline. It sits between the execute stage and `wb_stage`. It accepts one instruction per handshake from execute and waits for the data-SRAM response when execute has issued a load or store request. It aligns and sign- or zero-extends load data, then hands `{gr_we, dest, final_result, pc, is_exc}` to write-back. It also drives forwarding and stall information back to decode.

## Interface
- `ES_TO_MS_BUS_WD`, 76: execute-to-memory bus width; `mycpu.h` macro.
- `MS_TO_WS_BUS_WD`, 71: memory-to-write-back bus width; `mycpu.h` macro.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `ws_allowin` in 1: write-back can accept an instruction.
- `ms_allowin` out 1: this stage can accept an instruction.
- `es_to_ms_valid` in 1: execute presents an instruction.
- `es_to_ms_bus` in 76: {res_from_mem[75], mem_op[74:72], gr_we[71], dest[70:66], alu_result[65:34], pc[33:2], is_exc[1], req_sent[0]}.
  - `mem_op` encoding: 000 ld.w, 001 ld.b, 010 ld.h, 101 ld.bu, 110 ld.hu.
- `ms_to_ws_valid` out 1: instruction valid to write-back.
- `ms_to_ws_bus` out 71: {gr_we[70], dest[69:65], final_result[64:33], pc[32:1], is_exc[0]}.
- `data_sram_data_ok` in 1: response strobe for the outstanding request.
- `data_sram_rdata` in 32: response data, valid with `data_ok`.
- `ms_to_ds_dest` out 5: destination, forced to 0 when invalid or when `gr_we`=0.
- `ms_to_ds_result` out 32: `final_result` for forwarding.
- `ms_to_ds_load_block` out 1: a valid load whose data has not yet returned; decode must stall.
- `ms_to_es_is_exc` out 1: `ms_valid & is_exc`; execute uses it to suppress new memory requests.

## Operation
- Registers:
  - `ms_valid`.
  - `es_to_ms_bus_r`.
  - `rdata_buf[31:0]` and `rdata_buf_valid`.
- Capture: on `ms_allowin & es_to_ms_valid`, load `es_to_ms_bus_r` and clear `rdata_buf_valid`. The bus register otherwise holds its value.
- `ms_valid`: when `ms_allowin`, it takes `es_to_ms_valid`; otherwise it holds.
- `wait_resp` = `ms_valid & req_sent & ~rdata_buf_valid`.
- `ms_ready_go` = `~wait_resp | data_sram_data_ok`.
- `ms_allowin` = `~ms_valid | (ms_ready_go & ws_allowin)`.
- `ms_to_ws_valid` = `ms_valid & ms_ready_go`.
- Response buffer: if `data_ok` arrives while `wait_resp` is high and `ws_allowin`=0, latch `rdata_buf` and set `rdata_buf_valid`. The buffer stays set until the instruction leaves.
- `cur_rdata` = `rdata_buf_valid ? rdata_buf : data_sram_rdata`.
- Load extraction uses `alu_result[1:0]`:
  - ld.w: the full word.
  - ld.b and ld.bu: byte `alu_result[1:0]`, i.e. bits [8k+7:8k].
  - ld.h and ld.hu: halfword `alu_result[1]`, i.e. bits [16h+15:16h].
  - Signed forms sign-extend to 32 bits; u forms zero-extend.
- `final_result` = `res_from_mem ? extracted : alu_result`.
- Stores (req_sent=1, res_from_mem=0) also wait for `data_ok`; the read data is ignored.
- Exception instruction (`is_exc`=1): `req_sent` is guaranteed 0 by execute. The instruction passes through with `gr_we` forwarded unchanged; write-back handles suppression.
- `ms_to_ds_load_block` = `ms_valid & res_from_mem & wait_resp & ~data_sram_data_ok`.
- Exactly one response is expected per accepted instruction with `req_sent`=1. A `data_ok` with no outstanding request is ignored.

## Timing
- Reset values: `ms_valid`=0, `es_to_ms_bus_r`=0, `rdata_buf_valid`=0, `rdata_buf`=0.
  - Hence `ms_to_ws_valid`=0, `ms_allowin`=1, `ms_to_ds_dest`=0, `ms_to_ds_load_block`=0, `ms_to_es_is_exc`=0.
  - `ms_to_ws_bus`=0.
- Non-memory instruction: one cycle in the stage; output valid in the cycle after capture.
- Load or store: leaves in the first cycle where `data_ok` is high (or the buffer is valid) and `ws_allowin`=1. The earliest exit is the capture+1 cycle, when `data_ok` arrives in that same cycle.
- `data_ok` and `ws_allowin` high together: pass through combinationally, with no buffering and no bubble.
- Back-to-back accept: a new instruction is captured in the same edge the previous one leaves.
- Reset asserted mid-wait: all state clears at the edge. Any later stray `data_ok` is ignored because `ms_valid`=0.

## Test plan
- ALU instruction: pc=0x1c000000, dest=5, result=0x12345678 -> one cycle later `ms_to_ws_valid`=1 and the bus carries dest 5, result 0x12345678.
- ld.b with addr low bits=3 and rdata=0x80FFFFFF, with `data_ok` 2 cycles after capture:
  - `load_block`=1 for 2 cycles.
  - Then final_result=0xFFFFFF80.
- ld.hu with addr[1]=1 and rdata=0xBEEF1234 -> final_result=0x0000BEEF. ld.h on the same data -> 0xFFFFBEEF.
- `data_ok` with rdata=0xCAFEF00D while `ws_allowin`=0 for 3 cycles:
  - The buffer holds the data.
  - When allowin rises, ld.w outputs 0xCAFEF00D exactly once.
- Store with req_sent=1 -> the stage stalls until `data_ok`, and `ms_allowin`=0 throughout the wait.
- Reset during a pending load, then `data_ok` pulses -> `ms_to_ws_valid` stays 0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: waits for the data-SRAM response of an issued load/store,
// aligns and extends load data, and forwards results and stall info to decode.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 76,
    parameter int MS_TO_WS_BUS_WD = 71
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [4:0]                 ms_to_ds_dest,
    output logic [31:0]                ms_to_ds_result,
    output logic                       ms_to_ds_load_block,
    output logic                       ms_to_es_is_exc
);

    logic                       ms_valid_reg;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_reg;
    logic [31:0]                rdata_buf_reg;
    logic                       rdata_buf_valid_reg;

    logic        res_from_mem;
    logic [2:0]  mem_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic        is_exc;
    logic        req_sent;

    assign {res_from_mem, mem_op, gr_we, dest, alu_result, pc, is_exc, req_sent} = es_to_ms_bus_reg;

    logic wait_resp;
    logic ms_ready_go;

    assign wait_resp      = ms_valid_reg & req_sent & ~rdata_buf_valid_reg;
    assign ms_ready_go    = ~wait_resp | data_sram_data_ok;
    assign ms_allowin     = ~ms_valid_reg | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid_reg & ms_ready_go;

    logic accept;
    logic leave;
    logic buf_capture;

    assign accept      = ms_allowin & es_to_ms_valid;
    assign leave       = ms_to_ws_valid & ws_allowin;
    // Response arrived but write-back is stalled: hold it so the SRAM side can move on.
    assign buf_capture = wait_resp & data_sram_data_ok & ~ws_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_reg        <= 1'b0;
            es_to_ms_bus_reg    <= '0;
            rdata_buf_reg       <= 32'd0;
            rdata_buf_valid_reg <= 1'b0;
        end else begin
            if (ms_allowin) begin
                ms_valid_reg <= es_to_ms_valid;
            end
            if (accept) begin
                es_to_ms_bus_reg <= es_to_ms_bus;
            end
            if (buf_capture) begin
                rdata_buf_reg       <= data_sram_rdata;
                rdata_buf_valid_reg <= 1'b1;
            end else if (accept || leave) begin
                rdata_buf_valid_reg <= 1'b0;
            end
        end
    end

    logic [31:0] cur_rdata;
    assign cur_rdata = rdata_buf_valid_reg ? rdata_buf_reg : data_sram_rdata;

    logic [7:0]  rdata_byte [4];
    logic [15:0] rdata_half [2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign rdata_byte[gi] = cur_rdata[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign rdata_half[gi] = cur_rdata[16*gi +: 16];
        end
    endgenerate

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        is_unsigned;
    logic [31:0] load_data;

    assign sel_byte    = rdata_byte[alu_result[1:0]];
    assign sel_half    = rdata_half[alu_result[1]];
    assign is_unsigned = mem_op[2];

    // mem_op[1:0] gives the access size (00 word, 01 byte, 10 half); mem_op[2] selects zero-extension.
    always_comb begin
        load_data = cur_rdata;
        case (mem_op[1:0])
            2'b01:   load_data = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
            2'b10:   load_data = {{16{~is_unsigned & sel_half[15]}}, sel_half};
            default: load_data = cur_rdata;
        endcase
    end

    logic [31:0] final_result;
    assign final_result = res_from_mem ? load_data : alu_result;

    assign ms_to_ws_bus        = {gr_we, dest, final_result, pc, is_exc};
    assign ms_to_ds_dest       = dest & {5{ms_valid_reg & gr_we}};
    assign ms_to_ds_result     = final_result;
    assign ms_to_ds_load_block = ms_valid_reg & res_from_mem & wait_resp & ~data_sram_data_ok;
    assign ms_to_es_is_exc     = ms_valid_reg & is_exc;

endmodule
